// File: rtl/da_fir_serial_core.sv
// Bit-serial distributed-arithmetic FIR sequencer: 4-tap delay line, MSB-first LUT
// addressing and shift-accumulate, valid/ready on both sides.
module da_fir_serial_core #(
  parameter  int DW = 8,
  parameter  int CW = 8,
  localparam int OW = DW + CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    lut_addr,
  input  logic [CW-1:0] lut_data,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  input  logic          out_ready
);
  localparam int KW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0][DW-1:0]    taps_q, taps_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [OW-1:0]  acc_q, acc_d;
  logic signed [OW-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [OW-1:0]  lut_ext;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign lut_ext   = {{DW{lut_data[CW-1]}}, lut_data};

  always_comb begin
    lut_addr = 4'b0;
    if (state_q == SHIFT)
      for (int i = 0; i < 4; i++) lut_addr[i] = taps_q[i][k_q];
  end

  always_comb begin
    state_d     = state_q;
    taps_d      = taps_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          taps_d  = {taps_q[2:0], in_data};
          k_d     = KW'(DW - 1);
          acc_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The sign bit carries negative weight in two's complement, hence -L.
        if (k_q == KW'(DW - 1)) acc_d = -lut_ext;
        else                    acc_d = (acc_q <<< 1) + lut_ext;
        if (k_q == '0) begin
          out_data_d  = acc_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      taps_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      taps_q      <= taps_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_da_fir_serial_core.sv
// Directed + randomized bench for da_fir_serial_core against a direct-form FIR model
// (h = 1,2,3,4) with a behavioural coefficient LUT.
module tb_da_fir_serial_core;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int OW = DW + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [3:0]    lut_addr;
  logic [CW-1:0] lut_data;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready;

  int checks = 0;
  int errors = 0;
  int taps[4];
  longint last_out;
  logic [31:0] last_trace;

  da_fir_serial_core #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // LUT: sum of h_i over the taps whose address bit is set.
  always_comb lut_data = CW'(int'(lut_addr[0]) + 2 * int'(lut_addr[1])
                           + 3 * int'(lut_addr[2]) + 4 * int'(lut_addr[3]));

  function automatic int model_y();
    return taps[0] + 2 * taps[1] + 3 * taps[2] + 4 * taps[3];
  endfunction

  function automatic logic [3:0] model_addr(input int k);
    logic [3:0] a;
    for (int i = 0; i < 4; i++) a[i] = taps[i][k];
    return a;
  endfunction

  function automatic void model_push(input logic [DW-1:0] d);
    taps[3] = taps[2];
    taps[2] = taps[1];
    taps[1] = taps[0];
    taps[0] = int'($signed(d));
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) taps[i] = 0;
  endtask

  // Send one sample, follow it through SHIFT, optionally stall DONE for 'hold' cycles.
  task automatic run_sample(input logic [DW-1:0] d, input int hold);
    int w, lat;
    logic [31:0] tr, etr;
    logic irdy_ok, hold_ok;
    logic [OW-1:0] held;
    longint ey;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    chk("in_ready_before_send", longint'(in_ready), 1);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(d);
    ey = longint'(model_y());
    etr = '0;
    for (int j = 0; j < DW; j++) etr[j*4 +: 4] = model_addr(DW - 1 - j);
    tr = '0;
    tr[3:0] = lut_addr;
    irdy_ok = !in_ready;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
      if (n < DW) tr[n*4 +: 4] = lut_addr;
      if (in_ready) irdy_ok = 1'b0;
    end
    chk("latency", longint'(lat), DW);
    chk("in_ready_low_busy", longint'(irdy_ok), 1);
    chk("in_ready_low_done", longint'(in_ready), 0);
    chk("out_data", longint'($signed(out_data)), ey);
    chk("lut_addr_trace", longint'(tr), longint'(etr));
    last_out = longint'($signed(out_data));
    last_trace = tr;
    if (hold > 0) begin
      out_ready = 1'b0;
      held = out_data;
      hold_ok = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!out_valid || out_data !== held || in_ready || lut_addr != 4'b0) hold_ok = 1'b0;
      end
      chk("backpressure_hold", longint'(hold_ok), 1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("out_valid_drop", longint'(out_valid), 0);
    chk("in_ready_back", longint'(in_ready), 1);
  endtask

  initial begin
    int accepts, outs;
    logic r, seq_ok;
    int exp_seq[5];
    int got[5];
    int q[$];

    do_reset();
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_lut_addr", longint'(lut_addr), 0);

    // Impulse response
    run_sample(8'd1, 0); chk("impulse0", last_out, 1);
    run_sample(8'd0, 0); chk("impulse1", last_out, 2);
    run_sample(8'd0, 0); chk("impulse2", last_out, 3);
    run_sample(8'd0, 0); chk("impulse3", last_out, 4);

    // Extremes and sign handling
    do_reset();
    run_sample(8'h80, 0); chk("neg128", last_out, -128);
    run_sample(8'h7F, 0);
    run_sample(8'h7F, 0);
    run_sample(8'h7F, 0); chk("mixed_250", last_out, 250);
    run_sample(8'h7F, 0); chk("max_1270", last_out, 1270);

    // Backpressure
    run_sample(DW'($urandom), 5);

    // Randomized samples with random DONE stalls
    for (int i = 0; i < 12; i++)
      run_sample(DW'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

    // in_valid held high with incrementing data
    do_reset();
    exp_seq = '{1, 4, 10, 20, 30};
    accepts = 0; outs = 0; seq_ok = 1'b1;
    in_data = 8'd1; in_valid = 1'b1;
    for (int c = 0; c < 300 && outs < 5; c++) begin
      r = in_ready;
      @(posedge clk); #1;
      if (r) begin
        model_push(in_data);
        q.push_back(model_y());
        accepts++;
        in_data = in_data + 8'd1;
      end
      if (out_valid) begin
        got[outs] = int'($signed(out_data));
        if (q.size() == 0 || got[outs] != q.pop_front()) seq_ok = 1'b0;
        outs++;
      end
    end
    in_valid = 1'b0;
    chk("stuck_outputs", longint'(outs), 5);
    chk("stuck_accepts", longint'(accepts), 5);
    chk("stuck_vs_model", longint'(seq_ok), 1);
    for (int i = 0; i < 5; i++) chk($sformatf("stuck_out%0d", i), longint'(got[i]), longint'(exp_seq[i]));
    @(posedge clk); #1;

    // Reset during the third bit cycle
    run_sample(DW'($urandom_range(1, 127)), 0);
    in_valid = 1'b1; in_data = 8'h7F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_lut_addr0", longint'(lut_addr[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", longint'(out_valid), 0);
    chk("async_rst_out_data", longint'(out_data), 0);
    chk("async_rst_lut_addr", longint'(lut_addr), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) taps[i] = 0;
    run_sample(8'd5, 0); chk("post_rst_history_clear", last_out, 5);

    // lut_addr trace for 0x81
    do_reset();
    run_sample(8'h81, 0);
    chk("trace_0x81", longint'(last_trace), longint'(32'h1000_0001));
    chk("out_0x81", last_out, -127);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
